mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter on the multicycle core's data-memory port, beside the unified memory.
//  Decodes core address/memwrite/memread; bytes written to TXDATA enter a FIFO; an FSM serializes them as 8N1, LSB first.
//  Top level ORs rdata into the core read-data mux when sel=1.
// PARAMETERS
//  WIDTH         32            data/address width
//  BASE_ADDR     32'hFFFF0000  register window base, 8-byte aligned
//  CLKS_PER_BIT  16            clocks per serial bit, >=2
//  FIFO_DEPTH    4             TX FIFO entries, power of 2, >=2
// PORTS
//  clk        in   1      system clock, all state on rising edge
//  reset      in   1      synchronous, active-high reset
//  memwrite   in   1      core store strobe, one cycle
//  memread    in   1      core load strobe
//  addr       in   WIDTH  core byte address (ALU result)
//  writedata  in   WIDTH  core store data
//  rdata      out  WIDTH  register read data, combinational
//  sel        out  1      addr hits window, combinational
//  tx         out  1      serial line, idle high
//  busy       out  1      FIFO non-empty or frame in flight
// BEHAVIOUR
//  Decode: sel = (addr[WIDTH-1:3]==BASE_ADDR[WIDTH-1:3]); addr[2] selects register; addr[1:0] ignored.
//   addr[2]=0 TXDATA (write-only, reads 0); addr[2]=1 STATUS.
//  STATUS read = {WIDTH-3 zeros, overflow, full, busy}. rdata = 0 unless sel & memread.
//  TXDATA write (sel&memwrite&!addr[2]): push writedata[7:0] at that edge.
//   Full at push: byte dropped, overflow set (sticky).
//   Full is sampled before any same-cycle pop: push to full FIFO is dropped even if a pop occurs that edge.
//  STATUS write with writedata[2]=1 clears overflow. Other bits ignored. Set and clear in one cycle cannot occur.
//  FIFO: circular, wrapping rd/wr pointers, count 0..FIFO_DEPTH; full = (count==FIFO_DEPTH).
//  FSM states IDLE, START, DATA, STOP; bit counter 0..CLKS_PER_BIT-1; bit index 0..7.
//   IDLE: tx=1. If count!=0: pop into shift reg, enter START.
//    Push at edge N -> tx=0 after edge N+1.
//   START: tx=0 for CLKS_PER_BIT cycles -> DATA.
//   DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shift right, 8 bits -> STOP.
//   STOP: tx=1 for CLKS_PER_BIT cycles. At end, if count!=0 pop and go straight to START (no idle gap), else IDLE.
//  Frame = 10*CLKS_PER_BIT cycles. busy = (state!=IDLE)|(count!=0), registered-state derived.
//  Reset (any time, incl. mid-frame): after edge tx=1, state IDLE, FIFO flushed, overflow=0, busy=0.
//   Partial frame is aborted. sel/rdata follow inputs.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=FFFF0000)
//  Reset then read FFFF0004 -> rdata=0, tx=1, busy=0, sel=1. Read FFFF0000 -> rdata=0.
//  Write 0x55 to FFFF0000 at edge 0:
//   tx=0 cycles 1-4; then 1,0,1,0,1,0,1,0 each 4 cycles; tx=1 cycles 37-40; busy=0 from cycle 41.
//  Six writes A..F to TXDATA on consecutive edges from idle:
//   F dropped, STATUS=3'b111; exactly A..E sent back-to-back, 200 cycles, no idle gap.
//  After overflow, write 0x4 to FFFF0004 -> STATUS bit2=0; full/busy unaffected.
//  Reset asserted 10 cycles into a frame -> tx=1 next cycle, busy=0, queued bytes never sent.
//  Write to FFFF0008 and 00000000 -> sel=0, no push, tx stays 1, rdata=0.

Source files
------------

// File: rtl/mmio_uart_tx_if.sv
// Core data-memory port as seen by a memory-mapped peripheral.
// The core drives the strobes, address and store data; the peripheral answers with sel/rdata.
interface mmio_uart_tx_if #(
   parameter int WIDTH = 32
);
   logic             memwrite;
   logic             memread;
   logic [WIDTH-1:0] addr;
   logic [WIDTH-1:0] writedata;
   logic [WIDTH-1:0] rdata;
   logic             sel;

   modport master (
      output memwrite, memread, addr, writedata,
      input  rdata, sel
   );

   modport slave (
      input  memwrite, memread, addr, writedata,
      output rdata, sel
   );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes bytes into a small FIFO,
// STATUS reports {overflow, full, busy}; frames go out LSB first, back to back.
module mmio_uart_tx #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] BASE_ADDR    = 32'hFFFF0000,
   parameter int               CLKS_PER_BIT = 16,
   parameter int               FIFO_DEPTH   = 4
) (
   input  logic             clk,
   input  logic             reset,
   mmio_uart_tx_if.slave    bus,
   output logic             tx,
   output logic             busy
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          overflow_reg;
   logic [1:0]    state_reg, state_next;
   logic [BW-1:0] bitcnt_reg, bitcnt_next;
   logic [2:0]    bitidx_reg, bitidx_next;
   logic [7:0]    shift_reg, shift_next;
   logic          tx_reg, tx_next;

   logic wr_txdata, wr_status, full, empty, push, pop;
   logic [2:0] status;
   logic unused_bits;

   assign bus.sel   = (bus.addr[WIDTH-1:3] == BASE_ADDR[WIDTH-1:3]);
   assign wr_txdata = bus.sel & bus.memwrite & ~bus.addr[2];
   assign wr_status = bus.sel & bus.memwrite & bus.addr[2];
   assign full      = (count_reg == DEPTH_C);
   assign empty     = (count_reg == '0);
   // Full is judged on the registered count, so a same-edge pop never rescues a push.
   assign push      = wr_txdata & ~full;
   assign busy      = (state_reg != ST_IDLE) | ~empty;
   assign status    = {overflow_reg, full, busy};
   assign bus.rdata = (bus.sel & bus.memread & bus.addr[2]) ?
                      {{(WIDTH-3){1'b0}}, status} : '0;
   assign tx        = tx_reg;
   assign unused_bits = ^{bus.addr[1:0], bus.writedata[WIDTH-1:8]};

   always_comb begin
      state_next  = state_reg;
      bitcnt_next = bitcnt_reg;
      bitidx_next = bitidx_reg;
      shift_next  = shift_reg;
      pop         = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               shift_next = fifo_mem[rd_ptr_reg];
               state_next = ST_START;
               bitcnt_next = '0;
            end
         end
         ST_START: begin
            if (bitcnt_reg == BIT_LAST) begin
               bitcnt_next = '0;
               bitidx_next = '0;
               state_next  = ST_DATA;
            end else begin
               bitcnt_next = bitcnt_reg + 1'b1;
            end
         end
         ST_DATA: begin
            if (bitcnt_reg == BIT_LAST) begin
               bitcnt_next = '0;
               shift_next  = {1'b0, shift_reg[7:1]};
               if (bitidx_reg == 3'd7) begin
                  state_next = ST_STOP;
               end else begin
                  bitidx_next = bitidx_reg + 1'b1;
               end
            end else begin
               bitcnt_next = bitcnt_reg + 1'b1;
            end
         end
         default: begin
            if (bitcnt_reg == BIT_LAST) begin
               bitcnt_next = '0;
               // Chain the next queued byte straight into a start bit.
               if (!empty) begin
                  pop        = 1'b1;
                  shift_next = fifo_mem[rd_ptr_reg];
                  state_next = ST_START;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               bitcnt_next = bitcnt_reg + 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      tx_next = 1'b1;
      case (state_next)
         ST_START: tx_next = 1'b0;
         ST_DATA:  tx_next = shift_next[0];
         default:  tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= bus.writedata[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
         state_reg    <= ST_IDLE;
         bitcnt_reg   <= '0;
         bitidx_reg   <= '0;
         shift_reg    <= '0;
         tx_reg       <= 1'b1;
      end else begin
         wr_ptr_reg <= wr_ptr_reg + PW'(push);
         rd_ptr_reg <= rd_ptr_reg + PW'(pop);
         count_reg  <= count_reg + CW'(push) - CW'(pop);
         if (wr_txdata && full) begin
            overflow_reg <= 1'b1;
         end else if (wr_status && bus.writedata[2]) begin
            overflow_reg <= 1'b0;
         end
         state_reg  <= state_next;
         bitcnt_reg <= bitcnt_next;
         bitidx_reg <= bitidx_next;
         shift_reg  <= shift_next;
         tx_reg     <= tx_next;
      end
   end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: decode table, directed frame sequences,
// then random bus traffic against a queue-based line model.
module tb_mmio_uart_tx;
   localparam int          CPB   = 4;
   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'hFFFF0000;

   logic clk = 1'b0;
   logic reset;
   logic tx, busy;

   mmio_uart_tx_if #(.WIDTH(32)) bus ();

   mmio_uart_tx #(
      .WIDTH(32), .BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus), .tx(tx), .busy(busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Line model: pending bytes as a queue, the frame in flight as a byte plus a cycle offset.
   logic [7:0] q[$];
   logic [7:0] cur;
   bit         in_frame = 1'b0;
   bit         m_ovf = 1'b0;
   int         pos = 0;

   logic line_log [0:255];
   logic busy_log [0:255];
   int   lt;

   typedef struct {
      logic [31:0] addr;
      bit          mr;
      bit          exp_sel;
      logic [31:0] exp_rdata;
   } vec_t;
   vec_t vecs [8];

   function automatic bit m_sel(input logic [31:0] a);
      return (a >> 3) == (BASE >> 3);
   endfunction

   function automatic bit m_busy();
      return in_frame || (q.size() != 0);
   endfunction

   function automatic logic [2:0] m_status();
      return {m_ovf, q.size() == DEPTH, m_busy()};
   endfunction

   function automatic logic [31:0] m_rdata(input bit mr, input logic [31:0] a);
      if (m_sel(a) && mr && a[2]) return {29'd0, m_status()};
      return 32'd0;
   endfunction

   function automatic logic m_tx();
      int idx;
      if (!in_frame) return 1'b1;
      idx = pos / CPB;
      if (idx == 0) return 1'b0;
      if (idx == 9) return 1'b1;
      return cur[idx-1];
   endfunction

   task automatic m_edge(input bit rst, input bit mw, input logic [31:0] a, input logic [31:0] wd);
      bit was_full;
      if (rst) begin
         q.delete();
         in_frame = 1'b0;
         pos = 0;
         m_ovf = 1'b0;
         return;
      end
      was_full = (q.size() == DEPTH);
      if (in_frame) begin
         pos++;
         if (pos == 10*CPB) begin
            if (q.size() > 0) begin
               cur = q.pop_front();
               pos = 0;
            end else begin
               in_frame = 1'b0;
            end
         end
      end else if (q.size() > 0) begin
         cur = q.pop_front();
         pos = 0;
         in_frame = 1'b1;
      end
      if (mw && m_sel(a) && !a[2]) begin
         if (was_full) m_ovf = 1'b1;
         else q.push_back(wd[7:0]);
      end
      if (mw && m_sel(a) && a[2] && wd[2]) m_ovf = 1'b0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_bus(input bit mw, input bit mr, input logic [31:0] a, input logic [31:0] wd);
      bus.memwrite  = mw;
      bus.memread   = mr;
      bus.addr      = a;
      bus.writedata = wd;
   endtask

   task automatic finish_edge();
      @(posedge clk);
      m_edge(reset, bus.memwrite, bus.addr, bus.writedata);
      #1;
      chk("tx", tx, m_tx());
      chk("busy", busy, m_busy());
      lt++;
      if (lt >= 0 && lt < 256) begin
         line_log[lt] = tx;
         busy_log[lt] = busy;
      end
   endtask

   task automatic cyc(input bit mw, input bit mr, input logic [31:0] a, input logic [31:0] wd);
      set_bus(mw, mr, a, wd);
      #1;
      chk("sel", bus.sel, m_sel(a));
      chk("rdata", bus.rdata, m_rdata(mr, a));
      finish_edge();
   endtask

   task automatic write_reg(input logic [31:0] a, input logic [7:0] d);
      $display("write addr=%h data=%h", a, d);
      cyc(1'b1, 1'b0, a, {24'd0, d});
   endtask

   task automatic peek(input logic [31:0] a, output logic [31:0] rd);
      set_bus(1'b0, 1'b1, a, 32'd0);
      #1;
      rd = bus.rdata;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [7:0]  bytes6 [6];
      logic [7:0]  rx;
      int          first_idle, lows, expb;

      vecs[0] = '{32'hFFFF0004, 1'b1, 1'b1, 32'd0};
      vecs[1] = '{32'hFFFF0000, 1'b1, 1'b1, 32'd0};
      vecs[2] = '{32'hFFFF0007, 1'b1, 1'b1, 32'd0};
      vecs[3] = '{32'hFFFF0003, 1'b1, 1'b1, 32'd0};
      vecs[4] = '{32'hFFFF0008, 1'b1, 1'b0, 32'd0};
      vecs[5] = '{32'h00000000, 1'b1, 1'b0, 32'd0};
      vecs[6] = '{32'hFFFE0004, 1'b1, 1'b0, 32'd0};
      vecs[7] = '{32'hFFFF0004, 1'b0, 1'b1, 32'd0};
      bytes6 = '{8'h3C, 8'hA5, 8'h0F, 8'hF0, 8'h81, 8'h7E};

      lt = -1000;
      reset = 1'b1;
      set_bus(1'b0, 1'b0, 32'd0, 32'd0);
      repeat (3) finish_edge();
      reset = 1'b0;
      finish_edge();
      chk("reset_tx", tx, 1'b1);
      chk("reset_busy", busy, 1'b0);

      foreach (vecs[i]) begin
         set_bus(1'b0, vecs[i].mr, vecs[i].addr, 32'd0);
         #1;
         chk($sformatf("tbl%0d_sel", i), bus.sel, vecs[i].exp_sel);
         chk($sformatf("tbl%0d_rdata", i), bus.rdata, vecs[i].exp_rdata);
         finish_edge();
      end

      // Single 0x55 frame with explicit line timing.
      lt = -1;
      write_reg(BASE, 8'h55);
      for (int k = 1; k <= 41; k++) begin
         cyc(1'b0, 1'b0, 32'd0, 32'd0);
         if (k <= 4) expb = 0;
         else if (k <= 36) expb = (((k - 5) / 4) % 2 == 0) ? 1 : 0;
         else expb = 1;
         chk($sformatf("f55_tx_c%0d", k), tx, expb[0]);
         chk($sformatf("f55_busy_c%0d", k), busy, (k <= 40) ? 1'b1 : 1'b0);
      end

      // Six back-to-back writes: the sixth overflows.
      lt = -1;
      for (int i = 0; i < 6; i++) write_reg(BASE, bytes6[i]);
      peek(BASE + 32'd4, rd);
      chk("status_ovf", rd, 32'd7);
      finish_edge();
      write_reg(BASE + 32'd4, 8'h04);
      peek(BASE + 32'd4, rd);
      chk("status_clr", rd, 32'd3);
      finish_edge();
      while (lt < 210) cyc(1'b0, 1'b0, 32'd0, 32'd0);
      first_idle = -1;
      for (int t = 0; t <= 210; t++) begin
         if (first_idle < 0 && busy_log[t] == 1'b0) first_idle = t;
      end
      chk("burst_idle_cycle", first_idle, 201);
      for (int f = 0; f < 5; f++) begin
         for (int b = 0; b < 8; b++) rx[b] = line_log[1 + 40*f + 4 + 4*b + 2];
         chk($sformatf("burst_byte%0d", f), rx, bytes6[f]);
         chk($sformatf("burst_start%0d", f), line_log[1 + 40*f + 1], 1'b0);
         chk($sformatf("burst_stop%0d", f), line_log[1 + 40*f + 38], 1'b1);
      end

      // Reset ten cycles into a frame with more bytes queued.
      lt = -1;
      write_reg(BASE, 8'h00);
      write_reg(BASE, 8'h00);
      write_reg(BASE, 8'h00);
      repeat (8) cyc(1'b0, 1'b0, 32'd0, 32'd0);
      reset = 1'b1;
      cyc(1'b0, 1'b0, 32'd0, 32'd0);
      reset = 1'b0;
      chk("midreset_tx", tx, 1'b1);
      chk("midreset_busy", busy, 1'b0);
      peek(BASE + 32'd4, rd);
      chk("midreset_status", rd, 32'd0);
      finish_edge();
      lows = 0;
      repeat (90) begin
         cyc(1'b0, 1'b0, 32'd0, 32'd0);
         if (tx == 1'b0) lows++;
      end
      chk("midreset_no_resend", lows, 0);

      // Writes outside the window.
      write_reg(32'hFFFF0008, 8'h00);
      write_reg(32'h00000000, 8'h00);
      lows = 0;
      repeat (50) begin
         cyc(1'b0, 1'b0, 32'd0, 32'd0);
         if (tx == 1'b0 || busy == 1'b1) lows++;
      end
      chk("miss_no_push", lows, 0);

      // Random bus traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         int r;
         logic [31:0] ra;
         r  = $urandom_range(0, 99);
         ra = $urandom;
         if (r < 12) begin
            cyc(1'b1, 1'b0, BASE | {30'd0, ra[1:0]}, $urandom);
         end else if (r < 20) begin
            cyc(1'b0, 1'b1, BASE | {29'd1, ra[1:0]}, 32'd0);
         end else if (r < 23) begin
            cyc(1'b1, 1'b0, BASE | 32'd4, $urandom);
         end else if (r < 26) begin
            cyc(1'b0, 1'b1, BASE | {30'd0, ra[1:0]}, 32'd0);
         end else if (r < 30) begin
            cyc(1'b1, $urandom_range(0, 1) == 1, ra, $urandom);
         end else if (r == 30 && $urandom_range(0, 9) == 0) begin
            reset = 1'b1;
            cyc(1'b0, 1'b0, 32'd0, 32'd0);
            reset = 1'b0;
         end else begin
            cyc(1'b0, $urandom_range(0, 1) == 1, ra, 32'd0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
